// File: rtl/aryth_seq_alu_if.sv
// rtl/aryth_seq_alu_if.sv - pin-level bus bundle for the sequential ALU
interface aryth_seq_alu_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/aryth_seq_alu.sv
// rtl/aryth_seq_alu.sv - byte-serial sequential ALU; optional signed mode via ARYTH_SIGNED_EN
module aryth_seq_alu #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  aryth_seq_alu_if.slave bus
);
  localparam int RW = 2 * WIDTH;
  localparam int NB = RW / 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] C_LD_A    = 3'd0;
  localparam logic [2:0] C_LD_B    = 3'd1;
  localparam logic [2:0] C_GO      = 3'd2;
  localparam logic [2:0] C_RD_NEXT = 3'd3;
  localparam logic [2:0] C_RD_RST  = 3'd4;
  localparam logic [2:0] C_CLR     = 3'd5;

  logic [0:0]       r_state;
  logic             r_strb;
  logic [WIDTH-1:0] r_a, r_b, r_y;
  logic [RW-1:0]    r_r, r_x, r_acc;
  logic [2:0]       r_rd_ptr;
  logic [4:0]       r_cnt;
  logic             r_done, r_carry, r_err;
  logic             r_is_div, r_neg_q, r_neg_r;

  logic [2:0]       w_cmd, w_op;
  logic             w_accept, w_sgn;
  logic [WIDTH:0]   w_sum, w_diff;
  logic             w_ovf, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [RW-1:0]    w_go_r;
  logic             w_go_c, w_go_e, w_go_run;
  logic [RW-1:0]    w_acc_nxt, w_mul_fix;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt, w_rem_fix, w_quo_fix;

  assign w_cmd    = bus.uio_in[2:0];
  assign w_op     = bus.ui_in[2:0];
  // Rising edge of the strobe only, so a held strobe runs one command.
  assign w_accept = bus.uio_in[3] & ~r_strb & bus.ena;

`ifdef ARYTH_SIGNED_EN
  assign w_sgn = bus.ui_in[3];
`else
  assign w_sgn = 1'b0;
`endif

  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
  assign w_ovf   = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_diff[WIDTH-1] ^ r_a[WIDTH-1]);
  // Signed MUL/DIV run on magnitudes; the sign is fixed up when the result is stored.
  assign w_a_neg = w_sgn & r_a[WIDTH-1];
  assign w_b_neg = w_sgn & r_b[WIDTH-1];
  assign w_abs_a = w_a_neg ? -r_a : r_a;
  assign w_abs_b = w_b_neg ? -r_b : r_b;

  // One shift-add / restoring-division step per RUN cycle.
  assign w_acc_nxt = r_y[0] ? r_acc + r_x : r_acc;
  assign w_rem_sh  = {r_x[RW-1:WIDTH], r_x[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_y});
  assign w_rem_nxt = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_y}) : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_x[WIDTH-2:0], w_ge};
  assign w_mul_fix = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // Single-cycle results and whether GO has to enter RUN.
  always_comb begin
    w_go_r   = '0;
    w_go_c   = 1'b0;
    w_go_e   = 1'b0;
    w_go_run = 1'b0;
    case (w_op)
      3'd0: begin
        w_go_r = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        w_go_c = w_sum[WIDTH];
      end
      3'd1: begin
        w_go_r = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_go_c = w_sgn ? w_ovf : w_diff[WIDTH];
      end
      3'd2: w_go_run = 1'b1;
      3'd3: begin
        if (r_b == '0) begin
          w_go_r = {r_a, {WIDTH{1'b1}}};
          w_go_e = 1'b1;
        end else begin
          w_go_run = 1'b1;
        end
      end
      3'd4: w_go_r = {{WIDTH{1'b0}}, r_a & r_b};
      3'd5: w_go_r = {{WIDTH{1'b0}}, r_a | r_b};
      3'd6: w_go_r = {{WIDTH{1'b0}}, r_a ^ r_b};
      default: w_go_e = 1'b1;
    endcase
  end

  // Command decode, operand loading and the MUL/DIV iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_strb   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_r      <= '0;
      r_x      <= '0;
      r_acc    <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_carry  <= 1'b0;
      r_err    <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_strb <= bus.uio_in[3];
      if (w_accept && w_cmd == C_CLR) begin
        r_state  <= S_IDLE;
        r_a      <= '0;
        r_b      <= '0;
        r_r      <= '0;
        r_rd_ptr <= '0;
        r_done   <= 1'b0;
        r_carry  <= 1'b0;
        r_err    <= 1'b0;
      end else begin
        if (r_state == S_RUN) begin
          r_cnt <= r_cnt + 5'd1;
          if (r_is_div) begin
            r_x <= {w_rem_nxt, w_quo_nxt};
          end else begin
            r_acc <= w_acc_nxt;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
          end
          if (r_cnt == 5'(WIDTH - 1)) begin
            r_r     <= r_is_div ? {w_rem_fix, w_quo_fix} : w_mul_fix;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        if (w_accept && r_state == S_IDLE) begin
          case (w_cmd)
            C_LD_A: r_a <= WIDTH'({r_a, bus.ui_in});
            C_LD_B: r_b <= WIDTH'({r_b, bus.ui_in});
            C_GO: begin
              r_rd_ptr <= '0;
              r_carry  <= w_go_c;
              r_err    <= w_go_e;
              if (w_go_run) begin
                r_done   <= 1'b0;
                r_state  <= S_RUN;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_x      <= {{WIDTH{1'b0}}, w_abs_a};
                r_y      <= w_abs_b;
                r_is_div <= (w_op == 3'd3);
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
              end else begin
                r_done <= 1'b1;
                r_r    <= w_go_r;
              end
            end
            C_RD_NEXT: r_rd_ptr <= (r_rd_ptr == 3'(NB - 1)) ? 3'd0 : r_rd_ptr + 3'd1;
            C_RD_RST:  r_rd_ptr <= '0;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.uo_out  = 8'(r_r >> {r_rd_ptr, 3'b000});
  assign bus.uio_out = {r_err, r_carry, r_done, (r_state == S_RUN), 4'b0000};
  assign bus.uio_oe  = 8'hF0;
endmodule

// File: tb/tb_aryth_seq_alu.sv
// tb/tb_aryth_seq_alu.sv - self-checking bench driving WIDTH=8 and WIDTH=16 instances in lockstep
module tb_aryth_seq_alu;
  localparam logic [2:0] C_LD_A = 3'd0, C_LD_B = 3'd1, C_GO = 3'd2;
  localparam logic [2:0] C_RD_NEXT = 3'd3, C_RD_RST = 3'd4, C_CLR = 3'd5;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
    logic        c;
    logic        e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui = 8'h00;
  logic [7:0] uio = 8'h00;
  int         nchk = 0;
  int         nerr = 0;
  longint unsigned mA[2];
  longint unsigned mB[2];
  vec_t       tbl[11];

  aryth_seq_alu_if b8();
  aryth_seq_alu_if b16();
  assign b8.ena = ena;
  assign b8.ui_in = ui;
  assign b8.uio_in = uio;
  assign b16.ena = ena;
  assign b16.ui_in = ui;
  assign b16.uio_in = uio;

  aryth_seq_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  aryth_seq_alu #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int wid(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic longint unsigned msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(input longint unsigned v, input int w);
    if (((v >> (w - 1)) & 64'd1) != 0) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference behaviour from the arithmetic definitions of each op.
  task automatic model(input int w, input longint unsigned a, input longint unsigned b,
                       input int op, input bit sg, output longint unsigned r,
                       output bit c, output bit e);
    longint unsigned m = msk(w);
    longint sa = sx(a, w);
    longint sb = sx(b, w);
    longint t;
    longint maxv = (longint'(1) << (w - 1)) - 1;
    r = 0; c = 0; e = 0;
    case (op)
      0: begin t = longint'(a + b); r = a + b & m; c = ((t >> w) & 1) != 0; end
      1: begin
        r = (a - b) & m;
        if (sg) begin t = sa - sb; c = (t > maxv) || (t < -maxv - 1); end
        else c = a < b;
      end
      2: r = sg ? (longint'(sa * sb) & msk(2 * w)) : a * b;
      3: begin
        if (b == 0) begin r = (a << w) | m; e = 1; end
        else if (sg) r = ((longint'(sa % sb) & m) << w) | (longint'(sa / sb) & m);
        else r = ((a % b) << w) | (a / b);
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: begin r = 0; e = 1; end
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] c, input logic [7:0] d);
    uio = {4'b0000, 1'b1, c};
    ui = d;
    tick();
    uio = 8'h00;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [7:0] d);
    strobe(c, d);
    tick();
  endtask

  task automatic clr();
    cmd(C_CLR, 8'h00);
    for (int k = 0; k < 2; k++) begin mA[k] = 0; mB[k] = 0; end
  endtask

  task automatic ld_a(input logic [7:0] d);
    cmd(C_LD_A, d);
    for (int k = 0; k < 2; k++) mA[k] = ((mA[k] << 8) | d) & msk(wid(k));
  endtask

  task automatic ld_b(input logic [7:0] d);
    cmd(C_LD_B, d);
    for (int k = 0; k < 2; k++) mB[k] = ((mB[k] << 8) | d) & msk(wid(k));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((b8.uio_out[4] || b16.uio_out[4]) && n < 60) begin
      tick();
      n++;
    end
    check("wait_idle_bound", (n < 60), 1);
  endtask

  // Walk all result bytes; the 8-bit instance wraps its pointer twice meanwhile.
  task automatic read_both(output logic [63:0] r8, output logic [63:0] r16);
    cmd(C_RD_RST, 8'h00);
    r8 = 0;
    r16 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) r8 = r8 | (64'(b8.uo_out) << (8 * i));
      r16 = r16 | (64'(b16.uo_out) << (8 * i));
      cmd(C_RD_NEXT, 8'h00);
    end
  endtask

  task automatic go_run(input logic [2:0] op, input bit sg, output logic [63:0] r8,
                        output logic [63:0] r16);
    longint unsigned er[2];
    bit ec[2], ee[2], run[2];
    bit sge;
`ifdef ARYTH_SIGNED_EN
    sge = sg;
`else
    sge = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      model(wid(k), mA[k], mB[k], int'(op), sge, er[k], ec[k], ee[k]);
      run[k] = (op == 3'd2) || (op == 3'd3 && mB[k] != 0);
    end
    strobe(C_GO, {4'b0000, sg, op});
    check($sformatf("go_w8_op%0d_done_busy", op), {b8.uio_out[5], b8.uio_out[4]},
          run[0] ? 2'b01 : 2'b10);
    check($sformatf("go_w16_op%0d_done_busy", op), {b16.uio_out[5], b16.uio_out[4]},
          run[1] ? 2'b01 : 2'b10);
    tick();
    wait_idle();
    check("w8_flags", b8.uio_out, {ee[0], ec[0], 1'b1, 5'b0});
    check("w16_flags", b16.uio_out, {ee[1], ec[1], 1'b1, 5'b0});
    read_both(r8, r16);
    check($sformatf("w8_op%0d_result", op), r8, er[0]);
    check($sformatf("w16_op%0d_result", op), r16, er[1]);
  endtask

  initial begin
    logic [63:0] r8, r16;
    int n;

    tbl[0]  = '{3'd0, 8'hC8, 8'h64, 16'h002C, 1'b1, 1'b0};
    tbl[1]  = '{3'd1, 8'h05, 8'h07, 16'h00FE, 1'b1, 1'b0};
    tbl[2]  = '{3'd1, 8'h07, 8'h05, 16'h0002, 1'b0, 1'b0};
    tbl[3]  = '{3'd4, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0};
    tbl[4]  = '{3'd5, 8'hF0, 8'h3C, 16'h00FC, 1'b0, 1'b0};
    tbl[5]  = '{3'd6, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 1'b0};
    tbl[6]  = '{3'd7, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b1};
    tbl[7]  = '{3'd2, 8'h0F, 8'h0D, 16'h00C3, 1'b0, 1'b0};
    tbl[8]  = '{3'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0};
    tbl[9]  = '{3'd3, 8'h55, 8'h00, 16'h55FF, 1'b0, 1'b1};
    tbl[10] = '{3'd3, 8'hC8, 8'h07, 16'h041C, 1'b0, 1'b0};
    for (int k = 0; k < 2; k++) begin mA[k] = 0; mB[k] = 0; end

    tick();
    tick();
    check("reset_uo_out", b8.uo_out, 8'h00);
    check("reset_uio_out", b8.uio_out, 8'h00);
    check("reset_uio_oe", b8.uio_oe, 8'hF0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      clr();
      ld_a(tbl[i].a);
      ld_b(tbl[i].b);
      go_run(tbl[i].op, 1'b0, r8, r16);
      check($sformatf("tbl%0d_r", i), r8, 64'(tbl[i].r));
      check($sformatf("tbl%0d_c", i), b8.uio_out[6], tbl[i].c);
      check($sformatf("tbl%0d_e", i), b8.uio_out[7], tbl[i].e);
    end

    // MUL busy length, LD_A dropped while busy, byte pointer wrap.
    clr();
    ld_a(8'h0F);
    ld_b(8'h0D);
    strobe(C_GO, 8'h02);
    n = 0;
    while (b8.uio_out[4] && n < 40) begin
      n++;
      uio = (n == 2) ? {5'b00001, C_LD_A} : 8'h00;
      ui = 8'h99;
      tick();
    end
    uio = 8'h00;
    check("mul_busy_cycles", n, 8);
    check("mul_done_after_busy", b8.uio_out[5:4], 2'b10);
    wait_idle();
    cmd(C_RD_RST, 8'h00);
    check("rd_byte0", b8.uo_out, 8'hC3);
    cmd(C_RD_NEXT, 8'h00);
    check("rd_byte1", b8.uo_out, 8'h00);
    cmd(C_RD_NEXT, 8'h00);
    check("rd_wrap_byte0", b8.uo_out, 8'hC3);
    go_run(3'd0, 1'b0, r8, r16);
    check("ld_dropped_while_busy", r8, 64'h1C);

    // WIDTH=16 division, bytes 8E 00 06 00.
    clr();
    ld_a(8'h03);
    ld_a(8'hE8);
    ld_b(8'h00);
    ld_b(8'h07);
    go_run(3'd3, 1'b0, r8, r16);
    check("w16_div_bytes", r16, 64'h0006008E);

    // Held strobe runs once, then divide by zero.
    clr();
    uio = {5'b00001, C_LD_A};
    ui = 8'h55;
    for (int i = 0; i < 5; i++) tick();
    uio = 8'h00;
    tick();
    for (int k = 0; k < 2; k++) mA[k] = 64'h55;
    go_run(3'd3, 1'b0, r8, r16);
    check("div0_w8", r8, 64'h55FF);
    check("held_strobe_once_w16", r16, 64'h0055FFFF);

    // Commands ignored with ena low; running op still completes with ena low.
    clr();
    ena = 1'b0;
    cmd(C_GO, 8'h07);
    check("ena_low_ignored", b8.uio_out, 8'h00);
    ena = 1'b1;
    ld_a(8'h03);
    ld_b(8'h05);
    strobe(C_GO, 8'h02);
    ena = 1'b0;
    wait_idle();
    check("ena_low_completes", b8.uio_out[5], 1'b1);
    ena = 1'b1;
    read_both(r8, r16);
    check("ena_low_mul_r", r8, 64'h0F);

    // CLR aborts MUL in its third cycle.
    strobe(C_GO, 8'h02);
    tick();
    tick();
    strobe(C_CLR, 8'h00);
    for (int k = 0; k < 2; k++) begin mA[k] = 0; mB[k] = 0; end
    check("clr_abort_uio_out", b8.uio_out, 8'h00);
    check("clr_abort_uo_out", b8.uo_out, 8'h00);
    tick();

    // Signed MUL request.
    clr();
    ld_a(8'hFB);
    ld_b(8'h03);
    go_run(3'd2, 1'b1, r8, r16);
`ifdef ARYTH_SIGNED_EN
    check("signed_mul", r8, 64'hFFF1);
`else
    check("signed_mul_ignored", r8, 64'h02F1);
`endif

    // Randomized ops against the model.
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) ld_a(8'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        ld_b(8'h00);
        ld_b(8'h00);
      end else begin
        n = $urandom_range(1, 2);
        for (int j = 0; j < n; j++) ld_b(8'($urandom));
      end
      go_run(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), r8, r16);
    end

    // Asynchronous reset mid-RUN, after a nonzero result.
    clr();
    ld_a(8'h0F);
    ld_b(8'h0D);
    go_run(3'd0, 1'b0, r8, r16);
    strobe(C_GO, 8'h02);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_uo_out", b8.uo_out, 8'h00);
    check("async_rst_uio_out", b8.uio_out, 8'h00);
    check("async_rst_uio_out_w16", b16.uio_out, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
